// File: rtl/insn_buffer_pkg.sv
// RafiTypes: shared types and constants for the fetch-to-decode parcel buffer.
`default_nettype none
package RafiTypes;
  localparam int INSN_BUFFER_CAPACITY   = 8;
  localparam int INSN_BUFFER_ADDR_WIDTH = 32;
  localparam int PARCEL_WIDTH           = 16;

  typedef struct packed {
    logic [INSN_BUFFER_ADDR_WIDTH-1:0] pc;
    logic [PARCEL_WIDTH-1:0]           insn;
    logic                              fault;
  } InsnBufferEntry;
endpackage
`default_nettype wire

// File: rtl/insn_buffer_pointer.sv
// insn_buffer_pointer: wrapping pointer register, advances by 0/1/2, synchronous clear.
`default_nettype none
module insn_buffer_pointer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [1:0]       i_advance,
  output logic [WIDTH-1:0] o_ptr
);
  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= r_ptr + WIDTH'(i_advance);
    end
  end

  assign o_ptr = r_ptr;
endmodule
`default_nettype wire

// File: rtl/insn_buffer.sv
// insn_buffer: parcel FIFO between fetch and decode; splits 32-bit fetch words into
// 16-bit parcels tagged with pc and fault, pops one or two parcels per cycle.
`default_nettype none
module insn_buffer
  import RafiTypes::*;
#(
  parameter int CAPACITY   = INSN_BUFFER_CAPACITY,
  parameter int ADDR_WIDTH = INSN_BUFFER_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          write_valid,
  output logic                          write_ready,
  input  logic [ADDR_WIDTH-1:0]         write_pc,
  input  logic [31:0]                   write_insn,
  input  logic                          write_fault,
  input  logic                          read_low,
  input  logic                          read_high,
  output logic [ADDR_WIDTH+16:0]        read_entry_low,
  output logic [ADDR_WIDTH+16:0]        read_entry_high,
  output logic [$clog2(CAPACITY):0]     readable_entry_count
);
  localparam int PTR_W   = $clog2(CAPACITY);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + PARCEL_WIDTH + 1;

  logic [ENTRY_W-1:0]    r_mem [CAPACITY];
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      w_head;
  logic [PTR_W-1:0]      w_tail;
  logic [PTR_W-1:0]      w_head_next1;
  logic [PTR_W-1:0]      w_tail_next1;
  logic                  w_write_ready;
  logic                  w_accept;
  logic [1:0]            w_pushes;
  logic [1:0]            w_pops_req;
  logic [1:0]            w_pops;
  logic [ADDR_WIDTH-1:0] w_pc_base;
  logic [ADDR_WIDTH-1:0] w_pc_upper;
  logic [ENTRY_W-1:0]    w_entry_lo_half;
  logic [ENTRY_W-1:0]    w_entry_hi_half;
  logic                  w_unused_pc_bit0;

  assign w_unused_pc_bit0 = write_pc[0];

  assign w_write_ready = (r_count <= CNT_W'(CAPACITY - 2));
  assign w_accept      = write_valid && w_write_ready && !flush;
  assign w_pushes      = w_accept ? (write_pc[1] ? 2'd1 : 2'd2) : 2'd0;

  // Over-popping is dropped entirely rather than clamped, leaving state untouched.
  assign w_pops_req = {1'b0, read_low} + {1'b0, read_low & read_high};
  assign w_pops     = (!flush && (CNT_W'(w_pops_req) <= r_count)) ? w_pops_req : 2'd0;

  assign w_pc_base       = {write_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_pc_upper      = w_pc_base + ADDR_WIDTH'(2);
  assign w_entry_lo_half = {w_pc_base, write_insn[15:0], write_fault};
  assign w_entry_hi_half = {w_pc_upper, write_insn[31:16], write_fault};
  assign w_tail_next1    = w_tail + PTR_W'(1);
  assign w_head_next1    = w_head + PTR_W'(1);

  insn_buffer_pointer #(.WIDTH(PTR_W)) u_head (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (flush),
    .i_advance (w_pops),
    .o_ptr     (w_head)
  );

  insn_buffer_pointer #(.WIDTH(PTR_W)) u_tail (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (flush),
    .i_advance (w_pushes),
    .o_ptr     (w_tail)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (write_pc[1]) begin
        r_mem[w_tail] <= w_entry_hi_half;
      end else begin
        r_mem[w_tail]       <= w_entry_lo_half;
        r_mem[w_tail_next1] <= w_entry_hi_half;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_pushes) - CNT_W'(w_pops);
    end
  end

  assign write_ready          = w_write_ready;
  assign readable_entry_count = r_count;
  assign read_entry_low       = (r_count >= CNT_W'(1)) ? r_mem[w_head]       : '0;
  assign read_entry_high      = (r_count >= CNT_W'(2)) ? r_mem[w_head_next1] : '0;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    r_count <= CNT_W'(CAPACITY));
  a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(w_head + r_count[PTR_W-1:0]) == w_tail);
  a_high_without_low: assert property (@(posedge clk) disable iff (!rst)
    !(read_high && !read_low));
  a_no_over_pop: assert property (@(posedge clk) disable iff (!rst)
    flush || (CNT_W'(w_pops_req) <= r_count));
endmodule
`default_nettype wire

// File: tb/tb_insn_buffer.sv
// tb_insn_buffer: directed scoreboard bench for insn_buffer.
`default_nettype none
module tb_insn_buffer;
  import RafiTypes::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        write_valid = 1'b0;
  logic        write_ready;
  logic [31:0] write_pc = '0;
  logic [31:0] write_insn = '0;
  logic        write_fault = 1'b0;
  logic        read_low = 1'b0;
  logic        read_high = 1'b0;
  logic [48:0] read_entry_low;
  logic [48:0] read_entry_high;
  logic [3:0]  readable_entry_count;

  int errors = 0;
  int checks = 0;
  logic [48:0] q[$];

  always #5 clk = ~clk;

  insn_buffer #(.CAPACITY(8), .ADDR_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .write_valid          (write_valid),
    .write_ready          (write_ready),
    .write_pc             (write_pc),
    .write_insn           (write_insn),
    .write_fault          (write_fault),
    .read_low             (read_low),
    .read_high            (read_high),
    .read_entry_low       (read_entry_low),
    .read_entry_high      (read_entry_high),
    .readable_entry_count (readable_entry_count)
  );

  function automatic logic [48:0] mk(input logic [31:0] pc, input logic [15:0] insn, input logic f);
    InsnBufferEntry e;
    e.pc = pc;
    e.insn = insn;
    e.fault = f;
    return e;
  endfunction

  task automatic check_state(input string tag);
    logic [48:0] exp_lo;
    logic [48:0] exp_hi;
    logic [3:0]  exp_cnt;
    logic        exp_rdy;
    exp_cnt = 4'(q.size());
    exp_rdy = (q.size() <= 6);
    exp_lo  = (q.size() >= 1) ? q[0] : 49'd0;
    exp_hi  = (q.size() >= 2) ? q[1] : 49'd0;
    checks++;
    assert (readable_entry_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s count: got %0d expected %0d", tag, readable_entry_count, exp_cnt);
    end
    checks++;
    assert (write_ready === exp_rdy) else begin
      errors++;
      $error("FAIL %s write_ready: got %b expected %b", tag, write_ready, exp_rdy);
    end
    checks++;
    assert (read_entry_low === exp_lo) else begin
      errors++;
      $error("FAIL %s low: got %h expected %h", tag, read_entry_low, exp_lo);
    end
    checks++;
    assert (read_entry_high === exp_hi) else begin
      errors++;
      $error("FAIL %s high: got %h expected %h", tag, read_entry_high, exp_hi);
    end
  endtask

  // One clock: drive inputs, predict from the pre-edge queue, update scoreboard, check.
  task automatic step(input string tag, input logic wv, input logic [31:0] pc,
                      input logic [31:0] insn, input logic f,
                      input logic rl, input logic rh, input logic fl);
    bit acc;
    int pops;
    logic [31:0] base;
    write_valid = wv;
    write_pc    = pc;
    write_insn  = insn;
    write_fault = f;
    read_low    = rl;
    read_high   = rh;
    flush       = fl;
    acc  = wv && (q.size() <= 6) && !fl;
    pops = rl ? (rh ? 2 : 1) : 0;
    @(posedge clk);
    #1;
    write_valid = 1'b0;
    read_low    = 1'b0;
    read_high   = 1'b0;
    flush       = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      if (pops <= q.size()) repeat (pops) void'(q.pop_front());
      if (acc) begin
        base = {pc[31:2], 2'b00};
        if (!pc[1]) q.push_back(mk(base, insn[15:0], f));
        q.push_back(mk(base + 32'd2, insn[31:16], f));
      end
    end
    check_state(tag);
  endtask

  task automatic wr(input string tag, input logic [31:0] pc, input logic [31:0] insn, input logic f);
    step(tag, 1'b1, pc, insn, f, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag, input int n);
    step(tag, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, (n == 2), 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_state("reset");

    // Aligned write, then pop both.
    wr("aligned", 32'h1000, 32'hAAAA5555, 1'b0);
    checks++;
    assert (read_entry_high === mk(32'h1002, 16'hAAAA, 1'b0)) else begin
      errors++;
      $error("FAIL aligned_const high: got %h expected %h", read_entry_high, mk(32'h1002, 16'hAAAA, 1'b0));
    end
    rd("pop2", 2);

    // Unaligned single-parcel write, then an aligned one behind it.
    wr("unaligned", 32'h2002, 32'h12345678, 1'b0);
    wr("after_unaligned", 32'h2004, 32'h9ABCDEF0, 1'b0);
    rd("drain_a", 2);
    rd("drain_b", 1);

    // Fill to capacity; full buffer refuses a write even alongside a pop.
    wr("fill0", 32'h100, 32'h11110000, 1'b0);
    wr("fill1", 32'h104, 32'h33332222, 1'b0);
    wr("fill2", 32'h108, 32'h55554444, 1'b0);
    wr("fill3", 32'h10C, 32'h77776666, 1'b0);
    checks++;
    assert (write_ready === 1'b0) else begin
      errors++;
      $error("FAIL full_ready: got %b expected 0", write_ready);
    end
    step("full_wr_pop", 1'b1, 32'h110, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0);
    rd("full_drain_a", 2);
    rd("full_drain_b", 2);
    rd("full_drain_c", 2);

    // Bring pointers to 7 via flush, then straddle the wrap with an aligned write.
    step("flush0", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    wr("w_un", 32'h502, 32'hAAAA0000, 1'b0);
    wr("w_a0", 32'h504, 32'hBBBBCCCC, 1'b0);
    wr("w_a1", 32'h508, 32'hDDDDEEEE, 1'b0);
    wr("w_a2", 32'h50C, 32'hFFFF1111, 1'b0);
    rd("w_p0", 2);
    rd("w_p1", 2);
    rd("w_p2", 2);
    rd("w_p3", 1);
    wr("wrap", 32'h3000, 32'h87654321, 1'b0);
    rd("wrap_p0", 1);
    checks++;
    assert (read_entry_low[48:17] === 32'h3002) else begin
      errors++;
      $error("FAIL wrap_pc: got %h expected 3002", read_entry_low[48:17]);
    end
    rd("wrap_p1", 1);

    // Fault propagation.
    wr("fault1", 32'h4000, 32'hCAFEF00D, 1'b1);
    wr("fault0", 32'h4004, 32'h01234567, 1'b0);
    rd("fault_p0", 2);
    rd("fault_p1", 2);

    // Flush beats a same-cycle write.
    wr("pre_flush", 32'h6000, 32'h22221111, 1'b0);
    step("flush_wr", 1'b1, 32'h6004, 32'h44443333, 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-stream at count=5.
    wr("r0", 32'h7000, 32'h00010002, 1'b0);
    wr("r1", 32'h7004, 32'h00030004, 1'b0);
    wr("r2", 32'h700A, 32'h00050006, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    check_state("async_reset");
    @(negedge clk);
    rst = 1'b1;
    wr("post_reset", 32'h8000, 32'hABCD1234, 1'b1);
    rd("post_reset_pop", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
